// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for a single shared memory port.
// Grants are decoded from registered state; a hold limit forces handoff to a waiting master.
module mem_bus_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [DATA_W-1:0] m0_data_out,
  input  logic              m0_we,
  output logic              m0_gnt,
  output logic [DATA_W-1:0] m0_data_in,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [DATA_W-1:0] m1_data_out,
  input  logic              m1_we,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m1_data_in,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_out,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic              mem_we
);

  localparam int HOLD_W = $clog2(MAX_HOLD) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                last_srv_q, last_srv_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    last_srv_d = last_srv_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (m0_req && (!m1_req || last_srv_q)) begin
          state_d    = OWN0;
          last_srv_d = 1'b0;
          hold_cnt_d = '0;
        end else if (m1_req) begin
          state_d    = OWN1;
          last_srv_d = 1'b1;
          hold_cnt_d = '0;
        end
      end
      OWN0: begin
        if (!m0_req) begin
          if (m1_req) begin
            state_d    = OWN1;
            last_srv_d = 1'b1;
            hold_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (m1_req && hold_cnt_q == HOLD_LAST) begin
          state_d    = OWN1;
          last_srv_d = 1'b1;
          hold_cnt_d = '0;
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      OWN1: begin
        if (!m1_req) begin
          if (m0_req) begin
            state_d    = OWN0;
            last_srv_d = 1'b0;
            hold_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (m0_req && hold_cnt_q == HOLD_LAST) begin
          state_d    = OWN0;
          last_srv_d = 1'b0;
          hold_cnt_d = '0;
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments; the async reset forces IDLE, which drops every grant at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      last_srv_q <= 1'b1;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_srv_q <= last_srv_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // The ungranted master's signals never reach memory; mem_we also needs the owner to be requesting.
  always_comb begin
    m0_gnt       = (state_q == OWN0);
    m1_gnt       = (state_q == OWN1);
    mem_address  = '0;
    mem_data_out = '0;
    mem_we       = 1'b0;
    unique case (state_q)
      OWN0: begin
        mem_address  = m0_address;
        mem_data_out = m0_data_out;
        mem_we       = m0_we & m0_req;
      end
      OWN1: begin
        mem_address  = m1_address;
        mem_data_out = m1_data_out;
        mem_we       = m1_we & m1_req;
      end
      default: ;
    endcase
  end

  assign m0_data_in = mem_data_in;
  assign m1_data_in = mem_data_in;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a behavioural memory (combinational read, posedge write).
module tb_mem_bus_arbiter;

  logic        clk;
  logic        resetn;
  logic        m0_req, m0_we, m0_gnt;
  logic [31:0] m0_address, m0_data_out, m0_data_in;
  logic        m1_req, m1_we, m1_gnt;
  logic [31:0] m1_address, m1_data_out, m1_data_in;
  logic [31:0] mem_address, mem_data_out, mem_data_in;
  logic        mem_we;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:1023];
  logic        pre_we;
  logic [9:0]  pre_idx;
  logic [31:0] pre_data;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(8)) dut (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_address(m0_address), .m0_data_out(m0_data_out), .m0_we(m0_we),
    .m0_gnt(m0_gnt), .m0_data_in(m0_data_in),
    .m1_req(m1_req), .m1_address(m1_address), .m1_data_out(m1_data_out), .m1_we(m1_we),
    .m1_gnt(m1_gnt), .m1_data_in(m1_data_in),
    .mem_address(mem_address), .mem_data_out(mem_data_out),
    .mem_data_in(mem_data_in), .mem_we(mem_we)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_data_in = mem[mem_address[11:2]];

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (mem_we) mem[mem_address[11:2]] <= mem_data_out;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] data);
    pre_idx  = idx;
    pre_data = data;
    pre_we   = 1'b1;
    tick();
    pre_we   = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m1_req = 1'b0; m1_we = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    m0_req = 1'b1; m0_we = 1'b1; m0_address = 32'h10; m0_data_out = 32'h0BAD0BAD;
    m1_req = 1'b1; m1_we = 1'b1; m1_address = 32'h20; m1_data_out = 32'h0BAD0BAD;
    resetn = 1'b0;
    preload(10'h004, 32'h12345678);
    preload(10'h200, 32'h11111111);
    preload(10'h201, 32'h22222222);
    preload(10'h040, 32'h55555555);
    settle();
    checks++; if (m0_gnt !== 1'b0) begin failures++; $display("FAIL rst_m0_gnt got=%0h exp=0", m0_gnt); end
    checks++; if (m1_gnt !== 1'b0) begin failures++; $display("FAIL rst_m1_gnt got=%0h exp=0", m1_gnt); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%0h exp=0", mem_we); end
    checks++; if (mem_address !== 32'h0) begin failures++; $display("FAIL rst_mem_address got=%0h exp=0", mem_address); end
    checks++; if (mem_data_out !== 32'h0) begin failures++; $display("FAIL rst_mem_data_out got=%0h exp=0", mem_data_out); end
    m0_we = 1'b0; m1_we = 1'b0;
    tick();
    resetn = 1'b1;
    settle();
    checks++; if (m0_gnt !== 1'b0) begin failures++; $display("FAIL rel_no_comb_gnt got=%0h exp=0", m0_gnt); end
    tick();
    checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin failures++; $display("FAIL rel_first_gnt got=%0h/%0h exp=1/0", m0_gnt, m1_gnt); end
    checks++; if (mem_address !== 32'h10) begin failures++; $display("FAIL rel_mem_address got=%0h exp=10", mem_address); end
  endtask

  task automatic test_single_read();
    do_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_address = 32'h10;
    settle();
    checks++; if (m0_gnt !== 1'b0) begin failures++; $display("FAIL rd_gnt_cycle_n got=%0h exp=0", m0_gnt); end
    tick();
    checks++; if (m0_gnt !== 1'b1) begin failures++; $display("FAIL rd_gnt_cycle_n1 got=%0h exp=1", m0_gnt); end
    checks++; if (mem_address !== 32'h10) begin failures++; $display("FAIL rd_mem_address got=%0h exp=10", mem_address); end
    checks++; if (m0_data_in !== 32'h12345678) begin failures++; $display("FAIL rd_data got=%0h exp=12345678", m0_data_in); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rd_mem_we got=%0h exp=0", mem_we); end
    m0_req = 1'b0;
    tick();
    checks++; if (m0_gnt !== 1'b0 || mem_address !== 32'h0) begin failures++; $display("FAIL rd_back_idle got gnt=%0h addr=%0h exp 0/0", m0_gnt, mem_address); end
  endtask

  task automatic test_tie_handoff();
    do_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_address = 32'h10;
    m1_req = 1'b1; m1_we = 1'b0; m1_address = 32'h20;
    tick();
    checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin failures++; $display("FAIL tie_first got=%0h/%0h exp=1/0", m0_gnt, m1_gnt); end
    checks++; if (m1_data_in !== 32'h12345678) begin failures++; $display("FAIL tie_m1_data_in got=%0h exp=12345678", m1_data_in); end
    m0_req = 1'b0;
    tick();
    checks++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin failures++; $display("FAIL tie_gapless got=%0h/%0h exp=0/1", m0_gnt, m1_gnt); end
    checks++; if (mem_address !== 32'h20) begin failures++; $display("FAIL tie_m1_address got=%0h exp=20", mem_address); end
    m1_req = 1'b0;
    tick();
    checks++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin failures++; $display("FAIL tie_idle got=%0h/%0h exp=0/0", m0_gnt, m1_gnt); end
    m0_req = 1'b1; m1_req = 1'b1;
    tick();
    checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin failures++; $display("FAIL tie_after_m1 got=%0h/%0h exp=1/0", m0_gnt, m1_gnt); end
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
    m0_req = 1'b1; m1_req = 1'b1;
    tick();
    checks++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin failures++; $display("FAIL tie_after_m0 got=%0h/%0h exp=0/1", m0_gnt, m1_gnt); end
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    int n;
    do_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_address = 32'h40;
    tick();
    m1_req = 1'b1; m1_we = 1'b0; m1_address = 32'h44;
    n = 0;
    while (m0_gnt === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    checks++; if (n != 8) begin failures++; $display("FAIL hold_count got=%0d exp=8", n); end
    checks++; if (m1_gnt !== 1'b1 || mem_address !== 32'h44) begin failures++; $display("FAIL hold_handoff got gnt=%0h addr=%0h exp 1/44", m1_gnt, mem_address); end
    m1_req = 1'b0;
    tick();
    checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin failures++; $display("FAIL hold_return got=%0h/%0h exp=1/0", m0_gnt, m1_gnt); end
    m0_req = 1'b0;
    tick();
  endtask

  task automatic test_write_isolation();
    do_reset();
    m1_req = 1'b1; m1_we = 1'b1; m1_address = 32'h800; m1_data_out = 32'hDEADBEEF;
    tick();
    m0_req = 1'b1; m0_we = 1'b1; m0_address = 32'h804; m0_data_out = 32'h0;
    settle();
    checks++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin failures++; $display("FAIL wr_m1_owner got=%0h/%0h exp=0/1", m0_gnt, m1_gnt); end
    checks++; if (mem_we !== 1'b1 || mem_address !== 32'h800 || mem_data_out !== 32'hDEADBEEF) begin
      failures++; $display("FAIL wr_m1_bus got we=%0h addr=%0h data=%0h exp 1/800/deadbeef", mem_we, mem_address, mem_data_out); end
    tick();
    m1_req = 1'b0;
    settle();
    checks++; if (mem[10'h200] !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_m1_commit got=%0h exp=deadbeef", mem[10'h200]); end
    checks++; if (mem[10'h201] !== 32'h22222222) begin failures++; $display("FAIL wr_m0_not_yet got=%0h exp=22222222", mem[10'h201]); end
    checks++; if (mem_we !== 1'b0 || mem_address !== 32'h800) begin failures++; $display("FAIL wr_idle_owned got we=%0h addr=%0h exp 0/800", mem_we, mem_address); end
    tick();
    checks++; if (m0_gnt !== 1'b1 || mem_we !== 1'b1 || mem_address !== 32'h804 || mem_data_out !== 32'h0) begin
      failures++; $display("FAIL wr_m0_bus got gnt=%0h we=%0h addr=%0h data=%0h exp 1/1/804/0", m0_gnt, mem_we, mem_address, mem_data_out); end
    tick();
    m0_req = 1'b0; m0_we = 1'b0;
    settle();
    checks++; if (mem[10'h201] !== 32'h0) begin failures++; $display("FAIL wr_m0_commit got=%0h exp=0", mem[10'h201]); end
    checks++; if (mem[10'h200] !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_m1_kept got=%0h exp=deadbeef", mem[10'h200]); end
    m1_we = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    m0_req = 1'b1; m0_we = 1'b1; m0_address = 32'h100; m0_data_out = 32'hCAFEF00D;
    tick();
    settle();
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL arst_pre_we got=%0h exp=1", mem_we); end
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (m0_gnt !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL arst_async got gnt=%0h we=%0h exp 0/0", m0_gnt, mem_we); end
    m0_req = 1'b0; m0_we = 1'b0;
    tick();
    checks++; if (mem[10'h040] !== 32'h55555555) begin failures++; $display("FAIL arst_no_commit got=%0h exp=55555555", mem[10'h040]); end
    resetn = 1'b1;
    tick();
    checks++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin failures++; $display("FAIL arst_idle got=%0h/%0h exp=0/0", m0_gnt, m1_gnt); end
  endtask

  initial begin
    resetn = 1'b1;
    pre_we = 1'b0; pre_idx = '0; pre_data = '0;
    m0_req = 1'b0; m0_we = 1'b0; m0_address = '0; m0_data_out = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_address = '0; m1_data_out = '0;
    #1;
    test_reset();
    test_single_read();
    test_tie_handoff();
    test_starvation();
    test_write_isolation();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
